// File: rtl/progmem_arbiter_if.sv
// Word-addressed read bus shared by the progmem arbiter's master ports and its ROM port.
// The master modport drives address/read; the slave modport answers with data/response/stall.
interface progmem_arbiter_if #(
    parameter int unsigned ADDR_W = 10
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic [31:0]       readdata;
    logic [1:0]        response;
    logic              waitrequest;

    modport master (
        output address,
        output read,
        input  readdata,
        input  response,
        input  waitrequest
    );

    modport slave (
        input  address,
        input  read,
        output readdata,
        output response,
        output waitrequest
    );
endinterface

// File: rtl/progmem_arbiter.sv
// Two-master read arbiter in front of the one-wait-state program ROM; out-of-range reads are
// answered locally with SLVERR. Define PROGMEM_ARB_RR_EN for round-robin tie-breaking.
module progmem_arbiter #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned ROM_DEPTH = 1024
) (
    input  logic             clk,
    input  logic             rst,
    progmem_arbiter_if.slave  m0,
    progmem_arbiter_if.slave  m1,
    progmem_arbiter_if.master s
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StErr
    } state_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    state_e              state_q, state_d;
    logic                owner_q, owner_d;  // 0: m0, 1: m1
    logic                s_read_q, s_read_d;
    logic [ADDR_W-1:0]   s_address_q, s_address_d;

    logic                any_req;
    logic                grant;
    logic [ADDR_W-1:0]   win_addr;
    logic                win_err;
    logic                done_any;
    logic                done_ok;
    logic                done0, done1;
    logic [31:0]         done_data;
    logic [1:0]          done_resp;

    assign any_req  = m0.read | m1.read;
    assign win_addr = grant ? m1.address : m0.address;
    assign win_err  = 32'(win_addr) >= ROM_DEPTH;

`ifdef PROGMEM_ARB_RR_EN
    logic last_q, last_d;

    // On a tie the master not granted last time wins.
    always_comb begin
        grant = m1.read;
        if (m0.read && m1.read) begin
            grant = ~last_q;
        end
    end

    always_comb begin
        last_d = last_q;
        if (state_q == StIdle && any_req) begin
            last_d = grant;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    always_comb begin
        grant = ~m0.read;
    end
`endif

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        s_read_d    = s_read_q;
        s_address_d = s_address_q;
        done_any    = 1'b0;
        done_data   = 32'h0;
        done_resp   = RespOkay;

        unique case (state_q)
            StIdle: begin
                s_read_d = 1'b0;
                if (any_req) begin
                    owner_d = grant;
                    if (win_err) begin
                        state_d = StErr;
                    end else begin
                        state_d     = StIssue;
                        s_read_d    = 1'b1;
                        s_address_d = win_addr;
                    end
                end
            end
            StIssue: begin
                if (!s.waitrequest) begin
                    done_any  = 1'b1;
                    done_data = s.readdata;
                    done_resp = s.response;
                    s_read_d  = 1'b0;
                    state_d   = StIdle;
                end
            end
            StErr: begin
                done_any  = 1'b1;
                done_resp = RespSlvErr;
                state_d   = StIdle;
            end
            default: begin
                state_d  = StIdle;
                s_read_d = 1'b0;
            end
        endcase
    end

    // A completion coinciding with reset is dropped; the held request is rearbitrated.
    assign done_ok = done_any & ~rst;
    assign done0   = done_ok & ~owner_q;
    assign done1   = done_ok & owner_q;

    assign m0.waitrequest = m0.read & ~done0;
    assign m0.readdata    = done0 ? done_data : 32'h0;
    assign m0.response    = done0 ? done_resp : RespOkay;

    assign m1.waitrequest = m1.read & ~done1;
    assign m1.readdata    = done1 ? done_data : 32'h0;
    assign m1.response    = done1 ? done_resp : RespOkay;

    assign s.read    = s_read_q;
    assign s.address = s_address_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            owner_q     <= 1'b0;
            s_read_q    <= 1'b0;
            s_address_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            s_read_q    <= s_read_d;
            s_address_q <= s_address_d;
        end
    end

endmodule

// File: tb/tb_progmem_arbiter.sv
// Scoreboard bench for progmem_arbiter: directed reads push expected completions, a negedge
// monitor pops and compares them; a small one-wait-state ROM model answers the slave port.
module tb_progmem_arbiter;

    localparam int unsigned AW = 10;

    typedef struct packed {
        logic        mst;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    progmem_arbiter_if #(.ADDR_W(AW)) m0_bus ();
    progmem_arbiter_if #(.ADDR_W(AW)) m1_bus ();
    progmem_arbiter_if #(.ADDR_W(AW)) s_bus ();

    progmem_arbiter #(
        .ADDR_W   (AW),
        .ROM_DEPTH(512)
    ) dut (
        .clk(clk),
        .rst(rst),
        .m0 (m0_bus),
        .m1 (m1_bus),
        .s  (s_bus)
    );

    // ROM: one wait state per access, optionally stretched by force_wait.
    logic ack_q      = 1'b0;
    logic force_wait = 1'b0;
    assign s_bus.waitrequest = s_bus.read && (!ack_q || force_wait);
    assign s_bus.readdata    = (s_bus.address == 10'h005) ? 32'h0000_1234
                                                          : (32'hC0DE_0000 | 32'(s_bus.address));
    assign s_bus.response    = (s_bus.address == 10'h1FE) ? 2'b10 : 2'b00;
    always @(posedge clk) ack_q <= s_bus.read && s_bus.waitrequest;

    // s_read activity counters (sampled value of the cycle just ended).
    int   sread_rises = 0;
    int   sread_hi    = 0;
    logic sread_prev  = 1'b0;
    always @(posedge clk) begin
        if (s_bus.read) sread_hi++;
        if (s_bus.read && !sread_prev) sread_rises++;
        sread_prev = s_bus.read;
    end

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endfunction

    function automatic void mon_port(logic mst, logic rd, logic wr, logic [31:0] data,
                                     logic [1:0] resp);
        exp_t e;
        if (rd && !wr) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done m%0d: got data %h, want no completion", mst, data);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("done_owner_m%0d", mst), 32'(mst), 32'(e.mst));
                check($sformatf("done_data_m%0d", mst), data, e.data);
                check($sformatf("done_resp_m%0d", mst), 32'(resp), 32'(e.resp));
            end
        end else if (rd) begin
            check($sformatf("stall_data_m%0d", mst), data, 32'h0);
            check($sformatf("stall_resp_m%0d", mst), 32'(resp), 32'h0);
        end
    endfunction

    always @(negedge clk) begin
        mon_port(1'b0, m0_bus.read, m0_bus.waitrequest, m0_bus.readdata, m0_bus.response);
        mon_port(1'b1, m1_bus.read, m1_bus.waitrequest, m1_bus.readdata, m1_bus.response);
    end

    function automatic void push_exp(logic mst, logic [31:0] d, logic [1:0] r);
        exp_t e;
        e.mst  = mst;
        e.data = d;
        e.resp = r;
        exp_q.push_back(e);
    endfunction

    // One read; counts stall cycles before completion. keep leaves read asserted afterwards.
    task automatic do_read(input logic mst, input logic [9:0] addr, input logic [31:0] d,
                           input logic [1:0] r, input bit keep, input int extra,
                           output int stalls);
        bit fin;
        push_exp(mst, d, r);
        @(posedge clk);
        #1;
        if (mst) begin
            m1_bus.read    = 1'b1;
            m1_bus.address = addr;
        end else begin
            m0_bus.read    = 1'b1;
            m0_bus.address = addr;
        end
        if (extra > 0) force_wait = 1'b1;
        stalls = 0;
        fin    = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            if (mst ? !m1_bus.waitrequest : !m0_bus.waitrequest) begin
                fin = 1'b1;
            end else begin
                stalls++;
                if (force_wait && c == extra + 1) begin
                    @(posedge clk);
                    #1 force_wait = 1'b0;
                end
            end
        end
        force_wait = 1'b0;
        if (!fin) begin
            total++;
            bad++;
            $display("FAIL timeout m%0d addr %h: no completion in 40 cycles, want completion",
                     mst, addr);
        end
        if (!keep) begin
            @(posedge clk);
            #1;
            if (mst) m1_bus.read = 1'b0;
            else     m0_bus.read = 1'b0;
        end
    endtask

    task automatic clear_counts();
        @(posedge clk);
        #1;
        sread_rises = 0;
        sread_hi    = 0;
    endtask

    task automatic settle();
        repeat (2) @(posedge clk);
        #1;
    endtask

    int st;
    bit fin2;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want test done");
        $fatal(1, "watchdog");
    end

    initial begin
        m0_bus.read    = 1'b0;
        m0_bus.address = '0;
        m1_bus.read    = 1'b0;
        m1_bus.address = '0;
        rst            = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_read", 32'(s_bus.read), 32'h0);
        check("rst_s_address", 32'(s_bus.address), 32'h0);
        check("rst_m0_wr_idle", 32'(m0_bus.waitrequest), 32'h0);
        check("rst_m1_wr_idle", 32'(m1_bus.waitrequest), 32'h0);
        #2 m0_bus.read = 1'b1;
        #1 check("rst_m0_wr_follows_read", 32'(m0_bus.waitrequest), 32'h1);
        check("rst_m0_rdata", m0_bus.readdata, 32'h0);
        m0_bus.read = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // Valid read: two stalls, s_read high exactly two cycles
        clear_counts();
        do_read(1'b0, 10'h005, 32'h0000_1234, 2'b00, 1'b0, 0, st);
        check("t1_stalls", 32'(st), 32'd2);
        settle();
        check("t1_sread_hi", 32'(sread_hi), 32'd2);
        check("t1_sread_rises", 32'(sread_rises), 32'd1);

        // Out-of-range reads: local SLVERR, no slave access
        clear_counts();
        do_read(1'b1, 10'h3FF, 32'h0, 2'b10, 1'b0, 0, st);
        check("t2_stalls", 32'(st), 32'd1);
        do_read(1'b1, 10'h200, 32'h0, 2'b10, 1'b0, 0, st);
        check("t2_edge_stalls", 32'(st), 32'd1);
        settle();
        check("t2_sread_hi", 32'(sread_hi), 32'd0);

        // Last valid word, and slave response forwarding
        do_read(1'b1, 10'h1FF, 32'hC0DE_01FF, 2'b00, 1'b0, 0, st);
        check("t3_last_stalls", 32'(st), 32'd2);
        do_read(1'b1, 10'h1FE, 32'hC0DE_01FE, 2'b10, 1'b0, 0, st);
        check("t3_fwd_stalls", 32'(st), 32'd2);

        // Back-to-back with read held: IDLE gap, 3-cycle throughput
        clear_counts();
        do_read(1'b0, 10'h000, 32'hC0DE_0000, 2'b00, 1'b1, 0, st);
        check("t4_first_stalls", 32'(st), 32'd2);
        do_read(1'b0, 10'h001, 32'hC0DE_0001, 2'b00, 1'b0, 0, st);
        check("t4_second_stalls", 32'(st), 32'd2);
        settle();
        check("t4_sread_rises", 32'(sread_rises), 32'd2);
        check("t4_sread_hi", 32'(sread_hi), 32'd4);

        // ROM stretched by 5 extra wait cycles
        do_read(1'b0, 10'h0AA, 32'hC0DE_00AA, 2'b00, 1'b0, 5, st);
        check("t5_stalls", 32'(st), 32'd7);

        // Reset during ISSUE in the slave-ready cycle
        push_exp(1'b0, 32'hC0DE_0007, 2'b00);
        @(posedge clk);
        #1;
        m0_bus.read    = 1'b1;
        m0_bus.address = 10'h007;
        @(negedge clk);
        check("t6_c0_wr", 32'(m0_bus.waitrequest), 32'h1);
        @(negedge clk);
        check("t6_c1_sread", 32'(s_bus.read), 32'h1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("t6_rst_no_done", 32'(m0_bus.waitrequest), 32'h1);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t6_after_rst_sread", 32'(s_bus.read), 32'h0);
        check("t6_after_rst_wr", 32'(m0_bus.waitrequest), 32'h1);
        st   = 1;
        fin2 = 1'b0;
        for (int c = 0; c < 20 && !fin2; c++) begin
            @(negedge clk);
            if (!m0_bus.waitrequest) fin2 = 1'b1;
            else st++;
        end
        check("t6_retry_done", 32'(fin2), 32'h1);
        check("t6_retry_stalls", 32'(st), 32'd2);
        @(posedge clk);
        #1 m0_bus.read = 1'b0;

        // Simultaneous held requests after reset
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
`ifdef PROGMEM_ARB_RR_EN
        push_exp(1'b0, 32'hC0DE_0010, 2'b00);
        push_exp(1'b1, 32'hC0DE_0020, 2'b00);
        push_exp(1'b0, 32'hC0DE_0010, 2'b00);
        push_exp(1'b1, 32'hC0DE_0020, 2'b00);
`else
        for (int k = 0; k < 4; k++) push_exp(1'b0, 32'hC0DE_0010, 2'b00);
`endif
        @(posedge clk);
        #1;
        m0_bus.address = 10'h010;
        m1_bus.address = 10'h020;
        m0_bus.read    = 1'b1;
        m1_bus.read    = 1'b1;
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;
        m0_bus.read = 1'b0;
        m1_bus.read = 1'b0;
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/progmem_arbiter.md
# progmem_arbiter

Two-port read arbiter that shares the single program-ROM slave (the progmem wrapper: word-addressed, one-wait-state read) between an instruction-fetch master (m0) and a data/debug read master (m1). Sequences every ROM access through a small FSM so that the slave sees clean, isolated read transactions. Rejects out-of-range addresses locally with an error response, without touching the ROM. Sits between the CPU bus masters and the progmem wrapper.

## Interface
- ADDR_W, 10, word-address width of master and slave ports
- ROM_DEPTH, 1024, valid words; addresses >= ROM_DEPTH are errors
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- m0_address / m1_address  in  ADDR_W  master word address
- m0_read / m1_read  in  1  read request; held with address until completion
- m0_readdata / m1_readdata  out  32  read data, valid in completion cycle
- m0_response / m1_response  out  2  2'b00 OKAY, 2'b10 SLVERR; valid in completion cycle
- m0_waitrequest / m1_waitrequest  out  1  high stalls master
- s_address  out  ADDR_W  address to ROM wrapper (registered)
- s_read  out  1  read strobe to ROM wrapper (registered)
- s_readdata  in  32  ROM read data
- s_response  in  2  ROM response, forwarded to owner
- s_waitrequest  in  1  ROM stall

## Operation
- Master protocol: transaction completes in a cycle with mX_read=1 and mX_waitrequest=0; mX_waitrequest = mX_read && !doneX, where doneX is high only in the owner's completion cycle.
- FSM states: IDLE, ISSUE, ERR.
- IDLE: s_read=0. If any mX_read: choose winner, latch owner and its address. If latched address >= ROM_DEPTH -> ERR, else -> ISSUE with s_read<=1, s_address<=address.
- ISSUE: s_read held 1. When s_waitrequest=0: owner completes this cycle, readdata=s_readdata, response=s_response; s_read<=0; -> IDLE.
- ERR: owner completes this cycle, readdata=32'h0, response=2'b10; -> IDLE. No slave access.
- Non-owner: waitrequest high, readdata 0, response 0 throughout.
- s_read is always low for at least one cycle (IDLE) between slave transactions; required by the ROM wrapper's wait-state toggle.
- Arbitration (fixed, default): m0 wins on simultaneous request.
- Master dropping read mid-transaction is illegal; arbiter still finishes the slave access and discards data.

## Timing
- Reset values: s_read=0, s_address=0, state=IDLE, m*_waitrequest=m*_read, m*_readdata=0, m*_response=0, last-grant pointer=m1 (so m0 wins first).
- Valid read, ROM with one wait state: request seen cycle 0 (IDLE), s_read high cycles 1-2, master completes cycle 2. Two stall cycles.
- Error read: completes cycle 1; one stall cycle.
- Back-to-back requests: next arbitration in IDLE cycle after completion; sustained throughput one read per 3 cycles.
- rst mid-transaction: next edge state=IDLE, s_read=0; in-flight read not completed (waitrequest stays high while read held), rearbitrated after reset.
- Slave waitrequest held longer: ISSUE waits indefinitely, no timeout.

## Configuration
- PROGMEM_ARB_RR_EN defined: round-robin; on simultaneous request the master not granted last wins; pointer updates on each grant (including ERR).
- Undefined: fixed priority, m0 always wins ties; pointer logic absent.

## Test plan
- m0 reads addr 10'h005 (ROM word 0x0000_1234) -> m0_waitrequest high cycles 0-1, low cycle 2, m0_readdata=0x0000_1234, response 2'b00; s_read high exactly cycles 1-2.
- m1 reads 10'h3FF with ROM_DEPTH=512 -> completes cycle 1, readdata 0, response 2'b10, s_read never asserted.
- m0 and m1 request same cycle, held continuously: fixed mode -> m0 serviced repeatedly, m1 starved; RR mode -> grants alternate m0,m1,m0, each 3 cycles apart.
- Back-to-back m0 reads 0x000, 0x001 -> s_read low in cycle between transactions, second data correct (no duplicate completion).
- rst asserted during ISSUE -> next cycle s_read=0, state IDLE, no master completion; after deassert, held request serviced with correct data.
- ROM waitrequest forced high 5 extra cycles -> owner stalls, completes on first s_waitrequest=0 cycle with correct data.
